// File: rtl/dly_tap_ctrl_pkg.sv
// Shared types and widths for the I_DELAY tap sequencer.
// Optional timeout logic in dly_tap_ctrl is enabled by DLY_TAP_CTRL_TIMEOUT_EN.
package dly_tap_ctrl_pkg;

    localparam int TAP_W    = 6;
    localparam int TAP_MAX  = 63;
    localparam int SETTLE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        COMPARE,
        ADJ
    } state_e;

endpackage

// File: rtl/dly_tap_ctrl_if.sv
// Request and I_DELAY-side signals of the tap sequencer.
// master = calibration logic plus primitive feedback, slave = dly_tap_ctrl.
interface dly_tap_ctrl_if;
    import dly_tap_ctrl_pkg::*;

    logic             START;
    logic             LOAD_FIRST;
    logic [TAP_W-1:0] TARGET_TAP;
    logic [TAP_W-1:0] DLY_TAP_VALUE;
    logic             DLY_LOAD;
    logic             DLY_ADJ;
    logic             DLY_INCDEC;
    logic             BUSY;
    logic             DONE;
    logic             ERROR;

    modport master (
        output START, LOAD_FIRST, TARGET_TAP, DLY_TAP_VALUE,
        input  DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR
    );

    modport slave (
        input  START, LOAD_FIRST, TARGET_TAP, DLY_TAP_VALUE,
        output DLY_LOAD, DLY_ADJ, DLY_INCDEC, BUSY, DONE, ERROR
    );

endinterface

// File: rtl/dly_settle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module dly_settle_timer
    import dly_tap_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                done
);

    logic [SETTLE_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/dly_tap_ctrl.sv
// Walks an I_DELAY tap to a requested target using LOAD/ADJ pulses and tap feedback.
// Define DLY_TAP_CTRL_TIMEOUT_EN to add the MAX_STEPS step budget and ERROR pulse.
//
// state   | meaning
// IDLE    | waiting for START
// LOAD    | DLY_LOAD high for one cycle
// SETTLE  | outputs low, waiting SETTLE_CYCLES for the tap to update
// COMPARE | decide done / increment / decrement from DLY_TAP_VALUE
// ADJ     | DLY_ADJ high for one cycle
module dly_tap_ctrl
    import dly_tap_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_STEPS     = 70
) (
    input  logic          CLK_IN,
    input  logic          RESET,
    dly_tap_ctrl_if.slave bus
);

    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15 || MAX_STEPS < 1) begin : g_bad_param
        $error("dly_tap_ctrl: SETTLE_CYCLES must be 2-15 and MAX_STEPS at least 1");
    end

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_e           state_d, state_q;
    logic [TAP_W-1:0] target_d, target_q;
    logic             load_d, load_q;
    logic             adj_d, adj_q;
    logic             incdec_d, incdec_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             tmr_load, tmr_done;

`ifdef DLY_TAP_CTRL_TIMEOUT_EN
    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    logic [STEP_W-1:0] step_d, step_q;
    logic              err_d, err_q;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        load_d   = 1'b0;
        adj_d    = 1'b0;
        incdec_d = incdec_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
        step_d   = step_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    target_d = bus.TARGET_TAP;
                    busy_d   = 1'b1;
                    load_d   = bus.LOAD_FIRST;
                    state_d  = bus.LOAD_FIRST ? LOAD : SETTLE;
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
                    step_d   = '0;
`endif
                end
            end
            LOAD: state_d = SETTLE;
            SETTLE: begin
                if (tmr_done) state_d = COMPARE;
            end
            COMPARE: begin
                if (bus.DLY_TAP_VALUE == target_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
                end else if (step_q == STEP_W'(MAX_STEPS)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end else begin
                    // direction is registered together with the ADJ rise and held until the next compare
                    incdec_d = (bus.DLY_TAP_VALUE < target_q);
                    adj_d    = 1'b1;
                    state_d  = ADJ;
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
                    step_d   = step_q + STEP_W'(1);
`endif
                end
            end
            ADJ: state_d = SETTLE;
            default: state_d = IDLE;
        endcase
    end

    // reload the settle count only on entry, so the wait restarts after every pulse
    assign tmr_load = (state_d == SETTLE) && (state_q != SETTLE);

    dly_settle_timer u_settle (
        .clk      (CLK_IN),
        .rst      (RESET),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .done     (tmr_done)
    );

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            target_q <= '0;
            load_q   <= 1'b0;
            adj_q    <= 1'b0;
            incdec_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
            step_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            load_q   <= load_d;
            adj_q    <= adj_d;
            incdec_q <= incdec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
            step_q   <= step_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.DLY_LOAD   = load_q;
    assign bus.DLY_ADJ    = adj_q;
    assign bus.DLY_INCDEC = incdec_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
`ifdef DLY_TAP_CTRL_TIMEOUT_EN
    assign bus.ERROR      = err_q;
`else
    assign bus.ERROR      = 1'b0;
`endif

endmodule
